// File: rtl/sd_cmd_master_pkg.sv
// sd_cmd_master_pkg: shared definitions for the SD command-line engine.
//   - FSM state encoding
//   - response-type codes and frame/response lengths
//   - error/normal interrupt status bit positions
//   - command-register field positions
//   - helpers for response length and normal-status word
package sd_cmd_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_RECV     = 3'd3,
    ST_CHECK    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [1:0] RSP_NONE    = 2'b00;
  localparam logic [1:0] RSP_136     = 2'b01;
  localparam logic [1:0] RSP_48      = 2'b10;
  localparam logic [1:0] RSP_48_BUSY = 2'b11;

  localparam logic [7:0] TX_BITS     = 8'd48;
  localparam logic [7:0] RSP48_BITS  = 8'd48;
  localparam logic [7:0] RSP136_BITS = 8'd136;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_CRC     = 1;
  localparam int ERR_END     = 2;
  localparam int ERR_INDEX   = 3;
  localparam int NRM_CMD_COMPLETE = 0;
  localparam int NRM_ERROR        = 15;

  localparam int CMD_IDX_HI  = 13;
  localparam int CMD_IDX_LO  = 8;
  localparam int CMD_IDX_CHK = 4;
  localparam int CMD_CRC_CHK = 3;

  // Total response length including start and end bits; 48-bit-busy is plain 48-bit.
  function automatic logic [7:0] rsp_bits(input logic [1:0] rsp_type);
    return (rsp_type == RSP_136) ? RSP136_BITS : RSP48_BITS;
  endfunction

  // Normal status as seen at command completion.
  function automatic logic [15:0] nrm_word(input logic [15:0] err);
    logic [15:0] w;
    w = 16'd0;
    w[NRM_CMD_COMPLETE] = 1'b1;
    w[NRM_ERROR]        = |err;
    return w;
  endfunction

endpackage

// File: rtl/sd_cmd_master_crc7.sv
// sd_crc7: serial CRC7 (x^7 + x^3 + 1, init 0), one bit per enabled clock.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : return the CRC to 0 (wins over enable)
//   enable       : absorb din this clock
//   din          : serial data bit, MSB first
//   crc          : current remainder
module sd_crc7 (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       fb_s;

  assign fb_s = din ^ crc_q[6];

  // Next remainder: shift left, feedback into bit 0 and bit 3.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = 7'd0;
    end else if (enable) begin
      crc_d = {crc_q[5:3], crc_q[2] ^ fb_s, crc_q[1:0], fb_s};
    end else begin
      crc_d = crc_q;
    end
  end

  // Remainder register.
  always_ff @(posedge clock) begin
    if (reset) crc_q <= 7'd0;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_master.sv
// sd_cmd_master: SD CMD-line engine. Serialises a 48-bit command frame with CRC7,
// then receives and checks a 48- or 136-bit response.
//   clock, reset                  : system clock, synchronous active-high reset
//   sd_clk_en                     : one CMD bit shifted/sampled per enabled clock
//   start, command, argument,
//   timeout_control               : command request from the register file
//   cmd_in / cmd_out / cmd_oe     : CMD pin
//   busy, command_complete        : engine status
//   response_o, error_interrupt_status_o, normal_interrupt_status_o : results
module sd_cmd_master
  import sd_cmd_master_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sd_clk_en,
  input  logic         start,
  input  logic [15:0]  command,
  input  logic [31:0]  argument,
  input  logic [15:0]  timeout_control,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         busy,
  output logic         command_complete,
  output logic [127:0] response_o,
  output logic [15:0]  error_interrupt_status_o,
  output logic [15:0]  normal_interrupt_status_o
);

  state_e         state_q, state_d;
  logic [47:0]    tx_q, tx_d;
  logic [135:0]   rx_q, rx_d;
  logic [15:0]    tmo_cnt_q, tmo_cnt_d;
  logic [15:0]    tmo_lim_q, tmo_lim_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [15:0]    cmd_q, cmd_d;
  logic           cmd_out_q, cmd_out_d;
  logic           cmd_oe_q, cmd_oe_d;
  logic           busy_q, busy_d;
  logic           cc_q, cc_d;
  logic [127:0]   resp_q, resp_d;
  logic [15:0]    err_q, err_d;
  logic [15:0]    nrm_q, nrm_d;

  logic [6:0]     crc_tx_s, crc_rx_s;
  logic           crc_clear_s, tx_crc_en_s, rx_crc_en_s;
  logic [47:0]    frame_s;
  logic           rsp_long_s;
  logic [7:0]     rx_total_s;
  logic [5:0]     rx_idx_s;
  logic [15:0]    check_err_s;
  logic [127:0]   check_resp_s;
  logic [15:0]    tmo_inc_s;
  logic           unused_s;

  // CRC field left as zero here; it is substituted bit by bit while sending.
  assign frame_s    = {2'b01, command[CMD_IDX_HI:CMD_IDX_LO], argument, 7'd0, 1'b1};
  assign rsp_long_s = (cmd_q[1:0] == RSP_136);
  assign rx_total_s = rsp_bits(cmd_q[1:0]);
  assign rx_idx_s   = rsp_long_s ? rx_q[133:128] : rx_q[45:40];
  assign tmo_inc_s  = tmo_cnt_q + 16'd1;

  // Bit 0 of the frame is always 0 and leaves a zero CRC unchanged, so TX CRC
  // only needs bits 1..39, fed as they are launched.
  assign crc_clear_s = (state_q == ST_IDLE) && start;
  assign tx_crc_en_s = (state_q == ST_SEND) && sd_clk_en &&
                       (bit_cnt_q >= 8'd1) && (bit_cnt_q <= 8'd39);
  // bit_cnt counts bits received after the start bit; R2 CRC skips the 8-bit header.
  assign rx_crc_en_s = (state_q == ST_RECV) && sd_clk_en &&
                       (rsp_long_s ? ((bit_cnt_q >= 8'd8) && (bit_cnt_q <= 8'd127))
                                   : ((bit_cnt_q >= 8'd1) && (bit_cnt_q <= 8'd39)));

  assign check_err_s  = {12'd0,
                         cmd_q[CMD_IDX_CHK] && (rx_idx_s != cmd_q[CMD_IDX_HI:CMD_IDX_LO]),
                         ~rx_q[0],
                         cmd_q[CMD_CRC_CHK] && (rx_q[7:1] != crc_rx_s),
                         1'b0};
  assign check_resp_s = rsp_long_s ? {8'd0, rx_q[127:8]} : {96'd0, rx_q[39:8]};

  assign unused_s = ^{cmd_q[15:14], cmd_q[7:5], cmd_q[2], rx_q[135:134]};

  sd_crc7 u_crc_tx (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clear_s),
    .enable (tx_crc_en_s),
    .din    (tx_q[47]),
    .crc    (crc_tx_s)
  );

  sd_crc7 u_crc_rx (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clear_s),
    .enable (rx_crc_en_s),
    .din    (cmd_in),
    .crc    (crc_rx_s)
  );

  // Next-state and next-output logic of the command FSM.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_lim_d = tmo_lim_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    cmd_out_d = cmd_out_q;
    cmd_oe_d  = cmd_oe_q;
    cc_d      = 1'b0;
    resp_d    = resp_q;
    err_d     = err_q;
    nrm_d     = nrm_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cmd_d     = command;
          tmo_lim_d = (timeout_control == 16'd0) ? TIMEOUT_DEFAULT : timeout_control;
          // Bit 0 goes out immediately so the frame starts one clock after start.
          cmd_out_d = frame_s[47];
          cmd_oe_d  = 1'b1;
          tx_d      = {frame_s[46:0], 1'b0};
          bit_cnt_d = 8'd1;
          err_d     = 16'd0;
          nrm_d     = 16'd0;
          state_d   = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (sd_clk_en) begin
          if (bit_cnt_q == TX_BITS) begin
            cmd_oe_d  = 1'b0;
            cmd_out_d = 1'b1;
            tmo_cnt_d = 16'd0;
            bit_cnt_d = 8'd0;
            if (cmd_q[1:0] == RSP_NONE) begin
              nrm_d   = nrm_word(err_q);
              cc_d    = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_WAIT_RSP;
            end
          end else begin
            if ((bit_cnt_q >= 8'd40) && (bit_cnt_q <= 8'd46)) begin
              cmd_out_d = crc_tx_s[3'(8'd46 - bit_cnt_q)];
            end else begin
              cmd_out_d = tx_q[47];
            end
            tx_d      = {tx_q[46:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_RSP: begin
        if (sd_clk_en) begin
          if (!cmd_in) begin
            rx_d      = 136'd0;
            bit_cnt_d = 8'd1;
            state_d   = ST_RECV;
          end else if (tmo_inc_s == tmo_lim_q) begin
            err_d              = 16'd0;
            err_d[ERR_TIMEOUT] = 1'b1;
            nrm_d              = nrm_word(err_d);
            cc_d               = 1'b1;
            state_d            = ST_DONE;
          end else begin
            tmo_cnt_d = tmo_inc_s;
          end
        end else begin
          state_d = ST_WAIT_RSP;
        end
      end
      ST_RECV: begin
        if (sd_clk_en) begin
          rx_d      = {rx_q[134:0], cmd_in};
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (bit_cnt_q == (rx_total_s - 8'd1)) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_CHECK: begin
        err_d   = check_err_s;
        resp_d  = check_resp_s;
        nrm_d   = nrm_word(check_err_s);
        cc_d    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= 48'd0;
      rx_q      <= 136'd0;
      tmo_cnt_q <= 16'd0;
      tmo_lim_q <= 16'd0;
      bit_cnt_q <= 8'd0;
      cmd_q     <= 16'd0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      cc_q      <= 1'b0;
      resp_q    <= 128'd0;
      err_q     <= 16'd0;
      nrm_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_lim_q <= tmo_lim_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
      busy_q    <= busy_d;
      cc_q      <= cc_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      nrm_q     <= nrm_d;
    end
  end

  assign cmd_out                   = cmd_out_q;
  assign cmd_oe                    = cmd_oe_q;
  assign busy                      = busy_q;
  assign command_complete          = cc_q;
  assign response_o                = resp_q;
  assign error_interrupt_status_o  = err_q;
  assign normal_interrupt_status_o = nrm_q;

endmodule

// File: tb/tb_sd_cmd_master.sv
// tb_sd_cmd_master: directed bench for sd_cmd_master. A transaction model builds the
// expected per-cycle CMD-pin/busy/complete trace and final status/response from the
// protocol rules; one compare process checks the trace every cycle.
module tb_sd_cmd_master;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         sd_clk_en = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  command = 16'd0;
  logic [31:0]  argument = 32'd0;
  logic [15:0]  timeout_control = 16'd0;
  logic         cmd_in = 1'b1;
  logic         cmd_out, cmd_oe, busy, command_complete;
  logic [127:0] response_o;
  logic [15:0]  error_interrupt_status_o, normal_interrupt_status_o;

  sd_cmd_master dut (
    .clock                     (clock),
    .reset                     (reset),
    .sd_clk_en                 (sd_clk_en),
    .start                     (start),
    .command                   (command),
    .argument                  (argument),
    .timeout_control           (timeout_control),
    .cmd_in                    (cmd_in),
    .cmd_out                   (cmd_out),
    .cmd_oe                    (cmd_oe),
    .busy                      (busy),
    .command_complete          (command_complete),
    .response_o                (response_o),
    .error_interrupt_status_o  (error_interrupt_status_o),
    .normal_interrupt_status_o (normal_interrupt_status_o)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Expected trace, indexed by cycle since the start pulse (cycle 0 = start high).
  logic exp_busy [0:511];
  logic exp_oe   [0:511];
  logic exp_out  [0:511];
  logic exp_cc   [0:511];
  int   trace_len = 0;
  int   trace_cyc = 0;
  bit   trace_on  = 1'b0;
  logic [47:0]  cap_frame;
  logic [127:0] resp_model = 128'd0;
  logic [15:0]  err_exp;
  logic [47:0]  model_frame;

  // CRC7 as polynomial remainder of data * x^7 mod (x^7 + x^3 + 1); data = low n bits of d.
  function automatic logic [6:0] crc7_ref(input logic [135:0] d, input int n);
    logic [142:0] m;
    m = {7'd0, d} << 7;
    for (int i = n + 6; i >= 7; i--) begin
      if (m[i]) m = m ^ (143'h89 << (i - 7));
    end
    return m[6:0];
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Single compare process: pin-level trace, plus capture of the serial frame.
  always @(negedge clock) begin
    if (trace_on && trace_cyc < trace_len) begin
      vectors++;
      if ({busy, cmd_oe, cmd_out, command_complete} !==
          {exp_busy[trace_cyc], exp_oe[trace_cyc], exp_out[trace_cyc], exp_cc[trace_cyc]}) begin
        miscompares++;
        $display("FAIL trace cyc %0d: busy/oe/out/cc got %b%b%b%b want %b%b%b%b", trace_cyc,
                 busy, cmd_oe, cmd_out, command_complete,
                 exp_busy[trace_cyc], exp_oe[trace_cyc], exp_out[trace_cyc], exp_cc[trace_cyc]);
      end
      if (cmd_oe === 1'b1) cap_frame = {cap_frame[46:0], cmd_out};
      trace_cyc++;
    end
  end

  // One command. dv: enable divisor; gap: cycles between SEND end and reply start bit (-1 = no reply);
  // rst_at: cycle at which reset pulses (-1 none); start2_at: cycle of an extra start while busy.
  task automatic run(input logic [15:0] cmdw, input logic [31:0] arg, input logic [15:0] tmo,
                     input int dv, input int gap, input logic [135:0] reply,
                     input int rst_at, input int start2_at);
    logic [1:0] typ;
    bit         has_rsp;
    int         n, s, done, lim, len;
    logic [6:0] calc;
    logic [5:0] idx;
    typ     = cmdw[1:0];
    has_rsp = (typ != 2'b00);
    n       = (typ == 2'b01) ? 136 : 48;
    lim     = (tmo == 16'd0) ? 65535 : int'(tmo);
    s       = 49 + gap;
    model_frame = {2'b01, cmdw[13:8], arg,
                   crc7_ref(136'({2'b01, cmdw[13:8], arg}), 40), 1'b1};
    if (!has_rsp)      done = 48 * dv + 1;
    else if (gap >= 0) done = s + n + 1;
    else               done = 48 * dv + dv * lim + 1;
    len = (rst_at >= 0) ? rst_at + 8 : done + 3;
    for (int t = 0; t < len; t++) begin
      exp_busy[t] = 1'b0; exp_oe[t] = 1'b0; exp_out[t] = 1'b1; exp_cc[t] = 1'b0;
      if (rst_at < 0 || t <= rst_at) begin
        if (t >= 1 && t <= 48 * dv) begin
          exp_busy[t] = 1'b1; exp_oe[t] = 1'b1; exp_out[t] = model_frame[47 - (t - 1) / dv];
        end else if (t > 48 * dv && t <= done) begin
          exp_busy[t] = 1'b1; exp_cc[t] = (t == done);
        end
      end
    end
    // Outcome model.
    if (rst_at >= 0) begin
      err_exp = 16'd0; resp_model = 128'd0;
    end else if (!has_rsp) begin
      err_exp = 16'd0;
    end else if (gap < 0) begin
      err_exp = 16'h0001;
    end else begin
      if (n == 48) begin
        calc = crc7_ref(136'(reply[47:8]), 40); idx = reply[45:40];
        resp_model = {96'd0, reply[39:8]};
      end else begin
        calc = crc7_ref(136'(reply[127:8]), 120); idx = reply[133:128];
        resp_model = {8'd0, reply[127:8]};
      end
      err_exp = {12'd0, cmdw[4] && (idx != cmdw[13:8]), ~reply[0],
                 cmdw[3] && (reply[7:1] != calc), 1'b0};
    end
    cap_frame = 48'd0; trace_cyc = 0; trace_len = len; trace_on = 1'b1;
    timeout_control = tmo;
    for (int t = 0; t < len; t++) begin
      start     = (t == 0) || (t == start2_at);
      command   = (t == start2_at) ? 16'h3F02 : cmdw;
      argument  = (t == start2_at) ? 32'hFFFF_FFFF : arg;
      reset     = (t == rst_at);
      sd_clk_en = ((t % dv) == 0);
      cmd_in    = (has_rsp && gap >= 0 && t >= s && t < s + n) ? reply[n - 1 - (t - s)] : 1'b1;
      @(posedge clock); #1;
    end
    trace_on = 1'b0; start = 1'b0; reset = 1'b0; sd_clk_en = 1'b1; cmd_in = 1'b1;
    chk("error_status", 128'(error_interrupt_status_o), 128'(err_exp));
    chk("normal_status", 128'(normal_interrupt_status_o),
        (rst_at >= 0) ? 128'd0 : 128'({|err_exp, 14'd0, 1'b1}));
    chk("response", response_o, resp_model);
  endtask

  logic [119:0] payload;
  logic [135:0] r2;
  logic [47:0]  r9;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_out", 128'(cmd_out), 128'd1);
    chk("rst_outputs", 128'({cmd_oe, busy, command_complete}), 128'd0);
    chk("rst_status", 128'({error_interrupt_status_o, normal_interrupt_status_o}), 128'd0);
    chk("rst_response", response_o, 128'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // 1. CMD0, no response.
    run(16'h0000, 32'd0, 16'd16, 1, -1, 136'd0, -1, -1);
    chk("cmd0_model_frame", 128'(model_frame), 128'h400000000095);
    chk("cmd0_dut_frame", 128'(cap_frame), 128'h400000000095);
    chk("cmd0_status", 128'({error_interrupt_status_o, normal_interrupt_status_o}), 128'h0000_0001);

    // 2. CMD8 with valid R7.
    run(16'h081A, 32'h1AA, 16'd64, 1, 3, 136'h08000001AA13, -1, -1);
    chk("cmd8_dut_frame", 128'(cap_frame), 128'h48000001AA87);
    chk("cmd8_response", response_o, 128'h1AA);
    chk("cmd8_error", 128'(error_interrupt_status_o), 128'd0);

    // 3. Timeout after 16 enabled cycles.
    run(16'h081A, 32'h1AA, 16'd16, 1, -1, 136'd0, -1, -1);
    chk("tmo_status", 128'({error_interrupt_status_o, normal_interrupt_status_o}), 128'h0001_8001);

    // 4. CRC, index and end-bit errors.
    run(16'h081A, 32'h1AA, 16'd64, 1, 0, 136'h08000001AB13, -1, -1);
    chk("crc_err", 128'(error_interrupt_status_o), 128'h0002);
    r9 = {8'h09, 32'h1AA, crc7_ref(136'({8'h09, 32'h1AA}), 40), 1'b1};
    run(16'h081A, 32'h1AA, 16'd64, 1, 5, 136'(r9), -1, -1);
    chk("idx_err", 128'(error_interrupt_status_o), 128'h0008);
    run(16'h081A, 32'h1AA, 16'd64, 1, 1, 136'h08000001AA12, -1, -1);
    chk("end_err", 128'(error_interrupt_status_o), 128'h0004);

    // 5. R2 with 120-bit payload.
    payload = 120'h0123456789ABCDEF0123456789ABCD;
    r2 = {8'h3F, payload, crc7_ref(136'(payload), 120), 1'b1};
    run(16'h0209, 32'd0, 16'd64, 1, 2, r2, -1, -1);
    chk("r2_response", response_o, {8'h00, 120'h0123456789ABCDEF0123456789ABCD});
    chk("r2_error", 128'(error_interrupt_status_o), 128'd0);

    // 6. Reset at bit 20, start while busy, enable at half rate, start with reset.
    run(16'h081A, 32'h1AA, 16'd64, 1, 0, 136'h08000001AA13, 21, -1);
    run(16'h081A, 32'h1AA, 16'd64, 1, 4, 136'h08000001AA13, -1, 10);
    chk("busy_start_resp", response_o, 128'h1AA);
    run(16'h0000, 32'd0, 16'd16, 2, -1, 136'd0, -1, -1);
    run(16'h081A, 32'h1AA, 16'd5, 2, -1, 136'd0, -1, -1);
    chk("half_rate_tmo", 128'(error_interrupt_status_o), 128'h0001);
    run(16'h081A, 32'h1AA, 16'd64, 1, 0, 136'h08000001AA13, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
